// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
//
// Walks the pop-counter bank from index 0 to NUM_CNT-1 after an accepted
// start. Each index gets one read request. The bank's response, or a zero
// value on timeout, is forwarded as a report beat, and a running total is
// kept. A sweep runs only while the datapath reports idle. Dropping idle
// mid-sweep aborts the sweep.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   idle                  datapath idle; gates sweep start and continuation
//   start                 one-cycle sweep request
//   cnt_valid, cnt_data   counter bank response
//   req, idx              bank read request pulse and the index held with it
//   rpt_valid             one-cycle report beat
//   rpt_idx, rpt_data     index and value of the beat (value is 0 on timeout)
//   total                 sum of the current sweep's reported values
//   busy                  sweep in progress
//   done                  one-cycle pulse when a sweep completes normally
//   abort                 one-cycle pulse when a sweep is cut short by idle=0
//   timeout_err           sticky; set by any timeout, cleared by accepted start
module counter_sweep_ctrl #(
    parameter int unsigned NUM_CNT = 5,
    parameter int unsigned DATA_W  = 5,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idle,
    input  logic              start,
    input  logic              cnt_valid,
    input  logic [DATA_W-1:0] cnt_data,
    output logic              req,
    output logic [IDX_W-1:0]  idx,
    output logic              rpt_valid,
    output logic [IDX_W-1:0]  rpt_idx,
    output logic [DATA_W-1:0] rpt_data,
    output logic [DATA_W+2:0] total,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
    localparam logic [3:0]        TMO_LAST = 4'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [3:0]        wcnt;
    logic              accept;
    logic              take;
    logic              tmo;
    logic              adv;
    logic              abort_n;
    logic [DATA_W-1:0] beat_val;

    assign req  = (state == S_ISSUE);
    assign busy = (state == S_ISSUE) || (state == S_WAIT);
    assign done = (state == S_DONE);

    // The report beat goes out while the FSM is still in S_WAIT. That cycle
    // (rpt_valid=1) is the "beat+advance" slot. Response and timeout
    // detection are suppressed during it, so each index costs at least
    // ISSUE + WAIT + beat = 3 cycles.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        take     = 1'b0;
        tmo      = 1'b0;
        adv      = 1'b0;
        abort_n  = 1'b0;
        beat_val = '0;
        case (state)
            S_IDLE: begin
                if (start && idle) begin
                    accept  = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!idle) begin
                    abort_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!idle) begin
                    abort_n = 1'b1;
                    state_n = S_IDLE;
                end else if (rpt_valid) begin
                    adv     = 1'b1;
                    state_n = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
                end else if (cnt_valid) begin
                    take     = 1'b1;
                    beat_val = cnt_data;
                end else if (wcnt == TMO_LAST) begin
                    tmo = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            wcnt        <= '0;
            rpt_valid   <= 1'b0;
            rpt_idx     <= '0;
            rpt_data    <= '0;
            total       <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_n;
            rpt_valid <= take | tmo;
            abort     <= abort_n;

            if (accept) begin
                idx         <= '0;
                total       <= '0;
                timeout_err <= 1'b0;
                wcnt        <= '0;
            end

            if (state == S_ISSUE) begin
                wcnt <= '0;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt + 4'd1;
            end

            if (take || tmo) begin
                rpt_idx  <= idx;
                rpt_data <= beat_val;
                total    <= total + {3'b000, beat_val};
            end

            if (tmo) begin
                timeout_err <= 1'b1;
            end

            if (adv && (state_n == S_ISSUE)) begin
                idx <= idx + IDX_W'(1);
            end

            if (state == S_DONE) begin
                idx <= '0;
            end
        end
    end

endmodule
